// File: rtl/gmii_rx_stats_mc_if.sv
// Bus bundle for gmii_rx_stats_mc: GMII RX taps, snapshot/clear pulses and the 32-bit read port.
// Latency: none (wiring only).
// Backpressure: none; every signal is a plain strobe or level.
//
// master : drives taps, snap_req/clr_req and read requests, receives rd_data/rd_valid
// slave  : the statistics block
interface gmii_rx_stats_mc_if #(
    parameter int NUM_CH = 2
) ();
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [8*NUM_CH-1:0] gmii_rxd;
    logic [NUM_CH-1:0]   gmii_rx_dv;
    logic [NUM_CH-1:0]   gmii_rx_er;
    logic                snap_req;
    logic                clr_req;
    logic                rd_en;
    logic [CH_W-1:0]     rd_ch;
    logic [3:0]          rd_sel;
    logic [31:0]         rd_data;
    logic                rd_valid;

    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er, snap_req, clr_req, rd_en, rd_ch, rd_sel,
        input  rd_data, rd_valid
    );

    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er, snap_req, clr_req, rd_en, rd_ch, rd_sel,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/gmii_rx_stats_mc.sv
// Multi-channel GMII RX statistics: per-channel good/bad frame, octet and idle counters with a snapshot shadow.
// Latency: counters update the cycle after the event; rd_data/rd_valid one cycle after rd_en.
// Backpressure: none; taps are observed passively and every read is answered.
//
// Ports: aclk, rst (synchronous, active high); bus (gmii_rx_stats_mc_if.slave) carries
//   gmii_rxd/gmii_rx_dv/gmii_rx_er taps, snap_req, clr_req, rd_en/rd_ch/rd_sel in, rd_data/rd_valid out.
// Build option: define GMII_RX_STATS_CRC_EN for per-channel CRC-32 checking and the CRCERR counter.
module gmii_rx_stats_mc #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 64,
    parameter int MIN_OCTETS = 72
) (
    input  logic                      aclk,
    input  logic                      rst,
    gmii_rx_stats_mc_if.slave         bus
);
    localparam logic [31:0] NUM_CH_U    = NUM_CH;
    localparam logic [31:0] ID_WORD     = 32'h4752_5300 | NUM_CH_U;
    localparam logic [15:0] MIN_LEN     = 16'(MIN_OCTETS);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

`ifdef GMII_RX_STATS_CRC_EN
    // Reflected CRC-32, one octet per call, LSB first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction
`endif

    logic [NUM_CH-1:0][CNT_W-1:0] shd_good_all;
    logic [NUM_CH-1:0][CNT_W-1:0] shd_bad_all;
    logic [NUM_CH-1:0][CNT_W-1:0] shd_octets_all;
    logic [NUM_CH-1:0][CNT_W-1:0] shd_idle_all;
    logic [NUM_CH-1:0][CNT_W-1:0] shd_crcerr_all;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [7:0]       rxd;
        logic             dv;
        logic             er;
        state_t           state, state_nxt;
        logic             bad_flag, bad_flag_nxt;
        logic             sfd_seen, sfd_seen_nxt;
        logic             er_seen, er_seen_nxt;
        logic [15:0]      len, len_nxt;
        logic             frame_end;
        logic             frame_ok;
        logic             frame_good;
        logic [CNT_W-1:0] good_cnt, bad_cnt, octets_cnt, idle_cnt;
        logic [CNT_W-1:0] shd_good, shd_bad, shd_octets, shd_idle;

        assign rxd = bus.gmii_rxd[8*c +: 8];
        assign dv  = bus.gmii_rx_dv[c];
        assign er  = bus.gmii_rx_er[c];

        always_ff @(posedge aclk) begin
            if (rst) begin
                state    <= ST_IDLE;
                bad_flag <= 1'b0;
                sfd_seen <= 1'b0;
                er_seen  <= 1'b0;
                len      <= '0;
            end else begin
                state    <= state_nxt;
                bad_flag <= bad_flag_nxt;
                sfd_seen <= sfd_seen_nxt;
                er_seen  <= er_seen_nxt;
                len      <= len_nxt;
            end
        end

        always_comb begin
            state_nxt    = state;
            bad_flag_nxt = bad_flag;
            sfd_seen_nxt = sfd_seen;
            er_seen_nxt  = er_seen;
            len_nxt      = len;
            frame_end    = 1'b0;
            if (!dv) begin
                // Frame is evaluated from the registered flags in this cycle; flags start clean next frame.
                state_nxt    = ST_IDLE;
                frame_end    = (state != ST_IDLE);
                bad_flag_nxt = 1'b0;
                sfd_seen_nxt = 1'b0;
                er_seen_nxt  = 1'b0;
                len_nxt      = '0;
            end else begin
                len_nxt = (len == 16'hFFFF) ? len : len + 16'd1;
                if (er)
                    er_seen_nxt = 1'b1;
                case (state)
                    ST_IDLE: begin
                        state_nxt    = ST_PRE;
                        bad_flag_nxt = (rxd != 8'h55);
                    end
                    ST_PRE: begin
                        if (rxd == 8'hD5) begin
                            state_nxt    = ST_DATA;
                            sfd_seen_nxt = 1'b1;
                        end else if (rxd != 8'h55) begin
                            bad_flag_nxt = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign frame_ok = frame_end && !er_seen && !bad_flag && sfd_seen && (len >= MIN_LEN);

`ifdef GMII_RX_STATS_CRC_EN
        logic [31:0]      crc;
        logic             crc_bad;
        logic [CNT_W-1:0] crcerr_cnt, shd_crcerr;

        // Restart outside DATA so the register holds exactly the DATA octets at frame end.
        always_ff @(posedge aclk) begin
            if (rst)
                crc <= 32'hFFFF_FFFF;
            else if (state == ST_DATA && dv)
                crc <= crc32_step(crc, rxd);
            else if (state != ST_DATA)
                crc <= 32'hFFFF_FFFF;
        end

        assign crc_bad    = frame_end && (crc != CRC_RESIDUE);
        assign frame_good = frame_ok && !crc_bad;

        always_ff @(posedge aclk) begin
            if (rst) begin
                crcerr_cnt <= '0;
                shd_crcerr <= '0;
            end else begin
                if (bus.snap_req)
                    shd_crcerr <= crcerr_cnt;
                if (bus.clr_req)
                    crcerr_cnt <= '0;
                else
                    crcerr_cnt <= sat_inc(crcerr_cnt, crc_bad);
            end
        end

        assign shd_crcerr_all[c] = shd_crcerr;
`else
        assign frame_good        = frame_ok;
        assign shd_crcerr_all[c] = '0;
`endif

        // Snapshot takes the pre-increment values; clear overrides this cycle's increments.
        always_ff @(posedge aclk) begin
            if (rst) begin
                good_cnt   <= '0;
                bad_cnt    <= '0;
                octets_cnt <= '0;
                idle_cnt   <= '0;
                shd_good   <= '0;
                shd_bad    <= '0;
                shd_octets <= '0;
                shd_idle   <= '0;
            end else begin
                if (bus.snap_req) begin
                    shd_good   <= good_cnt;
                    shd_bad    <= bad_cnt;
                    shd_octets <= octets_cnt;
                    shd_idle   <= idle_cnt;
                end
                if (bus.clr_req) begin
                    good_cnt   <= '0;
                    bad_cnt    <= '0;
                    octets_cnt <= '0;
                    idle_cnt   <= '0;
                end else begin
                    good_cnt   <= sat_inc(good_cnt, frame_good);
                    bad_cnt    <= sat_inc(bad_cnt, frame_end && !frame_good);
                    octets_cnt <= sat_inc(octets_cnt, dv);
                    idle_cnt   <= sat_inc(idle_cnt, !dv);
                end
            end
        end

        assign shd_good_all[c]   = shd_good;
        assign shd_bad_all[c]    = shd_bad;
        assign shd_octets_all[c] = shd_octets;
        assign shd_idle_all[c]   = shd_idle;
    end

    logic [63:0] sel_word;
    logic [31:0] rd_word;
    logic        ch_ok;

    always_comb begin
        sel_word = '0;
        rd_word  = '0;
        ch_ok    = (32'(bus.rd_ch) < NUM_CH_U);
        case (bus.rd_sel[3:1])
            3'd0:    sel_word = 64'(shd_good_all[bus.rd_ch]);
            3'd1:    sel_word = 64'(shd_bad_all[bus.rd_ch]);
            3'd2:    sel_word = 64'(shd_octets_all[bus.rd_ch]);
            3'd3:    sel_word = 64'(shd_idle_all[bus.rd_ch]);
            3'd4:    sel_word = 64'(shd_crcerr_all[bus.rd_ch]);
            default: sel_word = '0;
        endcase
        rd_word = bus.rd_sel[0] ? sel_word[63:32] : sel_word[31:0];
        if (bus.rd_sel == 4'hF)
            rd_word = ID_WORD;
        if (!ch_ok)
            rd_word = '0;
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            bus.rd_data  <= bus.rd_en ? rd_word : 32'd0;
        end
    end
endmodule
